// File: rtl/rv32_pkg.sv
// Shared RV32 definitions: funct3 load/store encodings, MEM-stage FSM states,
// and small helpers for access alignment, byte enables and store-lane replication.
// Used by decode, ALU and the MEM stage; pure declarations, no logic or state.
package rv32_pkg;

   // funct3 encodings for loads and stores (stores use only B/H/W)
   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } mem_state_t;

   // funct3[1:0] carries the access size for both signed and unsigned loads:
   // 00 byte, 01 half, 10 word. The unused 11 code is treated as a word.
   function automatic logic is_aligned(input logic [2:0] func3, input logic [1:0] addr_lo);
      logic ok;
      case (func3[1:0])
         2'b00:   ok = 1'b1;
         2'b01:   ok = ~addr_lo[0];
         default: ok = (addr_lo == 2'b00);
      endcase
      return ok;
   endfunction

   // Loads and stores share the same byte-enable pattern.
   function automatic logic [3:0] byte_enables(input logic [2:0] func3, input logic [1:0] addr_lo);
      logic [3:0] be;
      case (func3[1:0])
         2'b00:   be = 4'b0001 << addr_lo;
         2'b01:   be = 4'b0011 << addr_lo;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   // Replicate the store operand across every lane so memory can pick
   // whichever lane the byte enables select, regardless of address.
   function automatic logic [31:0] replicate_store(input logic [2:0] func3, input logic [31:0] data);
      logic [31:0] wd;
      case (func3[1:0])
         2'b00:   wd = {4{data[7:0]}};
         2'b01:   wd = {2{data[15:0]}};
         default: wd = data;
      endcase
      return wd;
   endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: picks the addressed byte/half/word lane out of a
// 32-bit memory word and sign- or zero-extends it according to funct3.
// Purely combinational, zero latency, no handshake.
// Ports: i_rdata (raw memory word), i_addr_lo (byte offset), i_func3, o_data (extended result).
module load_align
   import rv32_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_addr_lo,
   input  logic [2:0]  i_func3,
   output logic [31:0] o_data
);

   logic [31:0] shifted;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   // Shift the addressed lane down to bit 0; alignment has already been
   // checked, so a halfword never straddles the top of the word.
   assign shifted = i_rdata >> {i_addr_lo, 3'b000};
   assign lane_b  = shifted[7:0];
   assign lane_h  = shifted[15:0];

   always_comb begin
      o_data = i_rdata;
      case (i_func3)
         F3_B:    o_data = {{24{lane_b[7]}}, lane_b};
         F3_H:    o_data = {{16{lane_h[15]}}, lane_h};
         F3_W:    o_data = i_rdata;
         F3_BU:   o_data = {24'd0, lane_b};
         F3_HU:   o_data = {16'd0, lane_h};
         default: o_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// RV32 MEM stage: issues loads/stores to data memory with a req/gnt/rvalid
// handshake, aligns and extends load data, and registers the writeback result.
// Latency: ALU ops 1 cycle; store >= 2 cycles of stall; load >= 3 cycles to writeback.
// Backpressure: o_stall holds the execute stage while a memory access is in flight.
// Ports:
//   i_clk, i_reset                    clock, synchronous active-high reset
//   i_valid, i_is_load, i_is_store,   instruction from execute: op kind, funct3,
//   i_func3, i_alu_result,            address/result, store operand and rd
//   i_store_data, i_rd
//   o_stall                           upstream hold
//   o_mem_req/we/addr/be/wdata,       data memory request side
//   i_mem_gnt
//   i_mem_rvalid, i_mem_rdata         data memory response side
//   o_wb_valid/rd/data                registered writeback (1-cycle strobe)
//   o_misaligned, o_bus_err           1-cycle exception pulses
module mem_access_stage
   import rv32_pkg::*;
#(
   parameter int unsigned RESP_TIMEOUT = 16   // legal range 2..255
)(
   input  logic        i_clk,
   input  logic        i_reset,

   input  logic        i_valid,
   input  logic        i_is_load,
   input  logic        i_is_store,
   input  logic [2:0]  i_func3,
   input  logic [31:0] i_alu_result,
   input  logic [31:0] i_store_data,
   input  logic [4:0]  i_rd,
   output logic        o_stall,

   output logic        o_mem_req,
   output logic        o_mem_we,
   output logic [31:0] o_mem_addr,
   output logic [3:0]  o_mem_be,
   output logic [31:0] o_mem_wdata,
   input  logic        i_mem_gnt,
   input  logic        i_mem_rvalid,
   input  logic [31:0] i_mem_rdata,

   output logic        o_wb_valid,
   output logic [4:0]  o_wb_rd,
   output logic [31:0] o_wb_data,
   output logic        o_misaligned,
   output logic        o_bus_err
);

   // Count value of the final permitted WAIT cycle; the counter starts at 0
   // on entry, so RESP_TIMEOUT WAIT cycles elapse before a bus error.
   localparam logic [7:0] CNT_LAST = 8'(RESP_TIMEOUT - 1);

   mem_state_t  state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;

   // Captured access, held steady across REQ and WAIT
   logic [31:0] addr_q, addr_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic        we_q, we_d;
   logic [2:0]  func3_q, func3_d;
   logic [4:0]  rd_q, rd_d;

   // Registered writeback and exception pulses
   logic        wb_valid_q, wb_valid_d;
   logic [4:0]  wb_rd_q, wb_rd_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic        misaligned_q, misaligned_d;
   logic        bus_err_q, bus_err_d;

   logic        mem_op;
   logic        aligned;
   logic [31:0] load_data;

   assign mem_op  = i_is_load | i_is_store;
   assign aligned = is_aligned(i_func3, i_alu_result[1:0]);

   // Lane select uses the captured offset, not the live ALU input, since
   // upstream may present the next instruction's fields by response time.
   load_align u_load_align (
      .i_rdata   (i_mem_rdata),
      .i_addr_lo (addr_q[1:0]),
      .i_func3   (func3_q),
      .o_data    (load_data)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      be_d         = be_q;
      wdata_d      = wdata_q;
      we_d         = we_q;
      func3_d      = func3_q;
      rd_d         = rd_q;
      wb_valid_d   = 1'b0;
      wb_rd_d      = wb_rd_q;
      wb_data_d    = wb_data_q;
      misaligned_d = 1'b0;
      bus_err_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (i_valid) begin
               if (!mem_op) begin
                  wb_valid_d = 1'b1;
                  wb_data_d  = i_alu_result;
                  wb_rd_d    = i_rd;
               end else if (!aligned) begin
                  // Faulting access never reaches the bus
                  misaligned_d = 1'b1;
               end else begin
                  state_d = REQ;
                  addr_d  = i_alu_result;
                  be_d    = byte_enables(i_func3, i_alu_result[1:0]);
                  wdata_d = replicate_store(i_func3, i_store_data);
                  we_d    = i_is_store;
                  func3_d = i_func3;
                  rd_d    = i_rd;
               end
            end
         end

         REQ: begin
            // rvalid here belongs to nobody and is dropped
            if (i_mem_gnt) begin
               if (we_q) begin
                  state_d = IDLE;
               end else begin
                  state_d = WAIT;
                  cnt_d   = 8'd0;
               end
            end
         end

         WAIT: begin
            // A response in the last permitted cycle still completes the load
            if (i_mem_rvalid) begin
               state_d    = IDLE;
               wb_valid_d = 1'b1;
               wb_data_d  = load_data;
               wb_rd_d    = rd_q;
               cnt_d      = 8'd0;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = IDLE;
               bus_err_d = 1'b1;
               cnt_d     = 8'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q      <= IDLE;
         cnt_q        <= 8'd0;
         addr_q       <= 32'd0;
         be_q         <= 4'd0;
         wdata_q      <= 32'd0;
         we_q         <= 1'b0;
         func3_q      <= 3'd0;
         rd_q         <= 5'd0;
         wb_valid_q   <= 1'b0;
         wb_rd_q      <= 5'd0;
         wb_data_q    <= 32'd0;
         misaligned_q <= 1'b0;
         bus_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         be_q         <= be_d;
         wdata_q      <= wdata_d;
         we_q         <= we_d;
         func3_q      <= func3_d;
         rd_q         <= rd_d;
         wb_valid_q   <= wb_valid_d;
         wb_rd_q      <= wb_rd_d;
         wb_data_q    <= wb_data_d;
         misaligned_q <= misaligned_d;
         bus_err_q    <= bus_err_d;
      end
   end

   // Stall covers the accept cycle combinationally so upstream holds the
   // instruction while it is captured; reset forces it low.
   assign o_stall = ~i_reset &
                    ((state_q != IDLE) | (i_valid & mem_op & aligned));

   assign o_mem_req    = (state_q == REQ);
   assign o_mem_we     = we_q;
   assign o_mem_addr   = {addr_q[31:2], 2'b00};
   assign o_mem_be     = be_q;
   assign o_mem_wdata  = wdata_q;

   assign o_wb_valid   = wb_valid_q;
   assign o_wb_rd      = wb_rd_q;
   assign o_wb_data    = wb_data_q;
   assign o_misaligned = misaligned_q;
   assign o_bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_valid, i_is_load, i_is_store;
   logic [2:0]  i_func3;
   logic [31:0] i_alu_result, i_store_data;
   logic [4:0]  i_rd;
   logic        o_stall;
   logic        o_mem_req, o_mem_we;
   logic [31:0] o_mem_addr;
   logic [3:0]  o_mem_be;
   logic [31:0] o_mem_wdata;
   logic        i_mem_gnt, i_mem_rvalid;
   logic [31:0] i_mem_rdata;
   logic        o_wb_valid;
   logic [4:0]  o_wb_rd;
   logic [31:0] o_wb_data;
   logic        o_misaligned, o_bus_err;

   int nvec = 0;
   int nerr = 0;

   localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd4, LHU = 3'd5;
   localparam int TIMEOUT = 16;

   always #5 i_clk = ~i_clk;

   mem_access_stage #(.RESP_TIMEOUT(TIMEOUT)) dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_valid(i_valid), .i_is_load(i_is_load), .i_is_store(i_is_store),
      .i_func3(i_func3), .i_alu_result(i_alu_result), .i_store_data(i_store_data),
      .i_rd(i_rd), .o_stall(o_stall),
      .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
      .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata), .i_mem_gnt(i_mem_gnt),
      .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
      .o_wb_valid(o_wb_valid), .o_wb_rd(o_wb_rd), .o_wb_data(o_wb_data),
      .o_misaligned(o_misaligned), .o_bus_err(o_bus_err)
   );

   // ---------------- reference model ----------------
   function automatic int nbytes(input logic [2:0] f3);
      if (f3 == LB || f3 == LBU) return 1;
      if (f3 == LH || f3 == LHU) return 2;
      return 4;
   endfunction

   function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
      logic [3:0] be;
      be = 4'b0000;
      for (int i = 0; i < nbytes(f3); i++) be[(addr % 4) + i] = 1'b1;
      return be;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
      if (nbytes(f3) == 1) return {4{d[7:0]}};
      if (nbytes(f3) == 2) return {2{d[15:0]}};
      return d;
   endfunction

   function automatic logic [31:0] m_load(input logic [31:0] rdata, input logic [31:0] addr,
                                          input logic [2:0] f3);
      longint unsigned v, span;
      int n;
      n    = nbytes(f3);
      span = 64'd1 << (8 * n);
      v    = {32'd0, rdata} >> (8 * (addr % 4));
      v    = v % span;
      if ((f3 == LB || f3 == LH) && v >= (span / 2)) v = v - span;
      return v[31:0];
   endfunction

   function automatic logic [2:0] rand_load_f3();
      logic [2:0] tbl [5];
      tbl = '{LB, LH, LW, LBU, LHU};
      return tbl[$urandom_range(0, 4)];
   endfunction

   function automatic logic [31:0] rand_aligned(input logic [2:0] f3);
      logic [31:0] a;
      a = $urandom;
      return a & ~(32'(nbytes(f3)) - 32'd1);
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle_inputs();
      i_valid = 0; i_is_load = 0; i_is_store = 0; i_func3 = 0;
      i_alu_result = 0; i_store_data = 0; i_rd = 0;
      i_mem_gnt = 0; i_mem_rvalid = 0; i_mem_rdata = 0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      i_reset = 1;
      idle_inputs();
      tick(); tick();
      nvec++;
      if ({o_stall, o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata,
           o_wb_valid, o_wb_rd, o_wb_data, o_misaligned, o_bus_err} !== '0) begin
         nerr++;
         $display("FAIL reset_outputs: got req=%b stall=%b addr=%h be=%h wd=%h wbv=%b rd=%0d wbd=%h mis=%b berr=%b, want all 0",
                  o_mem_req, o_stall, o_mem_addr, o_mem_be, o_mem_wdata, o_wb_valid,
                  o_wb_rd, o_wb_data, o_misaligned, o_bus_err);
      end
      i_reset = 0;
      tick();
   endtask

   // Consecutive ALU ops, one per cycle: each writes back the next cycle.
   task automatic test_passthrough(input int n);
      logic [31:0] prev_d;
      logic [4:0]  prev_rd;
      prev_d = 0; prev_rd = 0;
      for (int t = 0; t <= n; t++) begin
         if (t < n) begin
            i_valid = 1; i_is_load = 0; i_is_store = 0;
            i_func3 = 3'($urandom);
            i_alu_result = (t == 0) ? 32'h0000_1234 : $urandom;
            i_rd = (t == 0) ? 5'd5 : 5'($urandom);
         end else begin
            i_valid = 0;
         end
         #1;
         nvec++;
         if (o_stall !== 1'b0) begin
            nerr++; $display("FAIL alu_stall: got %b want 0", o_stall);
         end
         if (t > 0) begin
            nvec++;
            if ({o_wb_valid, o_wb_rd, o_wb_data} !== {1'b1, prev_rd, prev_d}) begin
               nerr++;
               $display("FAIL alu_wb: got v=%b rd=%0d d=%h want v=1 rd=%0d d=%h",
                        o_wb_valid, o_wb_rd, o_wb_data, prev_rd, prev_d);
            end
         end
         prev_d = i_alu_result; prev_rd = i_rd;
         tick();
      end
      nvec++;
      if (o_wb_valid !== 1'b0) begin
         nerr++; $display("FAIL alu_wb_pulse: got %b want 0", o_wb_valid);
      end
   endtask

   task automatic test_load(input int n);
      for (int t = 0; t < n; t++) begin
         logic [2:0]  f3;
         logic [31:0] addr, rdata, exp;
         logic [4:0]  rd;
         int gd, rdl;
         bit stray;
         f3 = rand_load_f3(); addr = rand_aligned(f3); rd = 5'($urandom);
         rdata = $urandom; gd = $urandom_range(0, 3); rdl = $urandom_range(0, 4);
         stray = ($urandom_range(0, 1) == 1);
         if (t == 0) begin
            f3 = LB; addr = 32'h0000_1003; rdata = 32'h80FF_0000; gd = 2; rdl = 0;
         end
         exp = m_load(rdata, addr, f3);
         i_valid = 1; i_is_load = 1; i_is_store = 0; i_func3 = f3;
         i_alu_result = addr; i_rd = rd; i_store_data = $urandom;
         #1;
         nvec++;
         if ({o_stall, o_mem_req} !== 2'b10) begin
            nerr++; $display("FAIL ld_accept: got stall=%b req=%b want 1,0", o_stall, o_mem_req);
         end
         tick();
         i_valid = 0;
         for (int g = 0; g <= gd; g++) begin
            i_mem_gnt = (g == gd);
            i_mem_rvalid = stray ? 1'($urandom) : 1'b0;
            i_mem_rdata = $urandom;
            #1;
            nvec++;
            if ({o_stall, o_mem_req, o_mem_we, o_mem_addr, o_mem_be} !==
                {1'b1, 1'b1, 1'b0, addr[31:2], 2'b00, m_be(f3, addr)}) begin
               nerr++;
               $display("FAIL ld_req: got stall=%b req=%b we=%b addr=%h be=%b want 1,1,0 addr=%h be=%b",
                        o_stall, o_mem_req, o_mem_we, o_mem_addr, o_mem_be,
                        {addr[31:2], 2'b00}, m_be(f3, addr));
            end
            tick();
         end
         i_mem_gnt = 0; i_mem_rvalid = 0;
         for (int w = 0; w < rdl; w++) begin
            #1;
            nvec++;
            if ({o_stall, o_mem_req, o_wb_valid} !== 3'b100) begin
               nerr++; $display("FAIL ld_wait: got stall=%b req=%b wbv=%b want 1,0,0",
                                o_stall, o_mem_req, o_wb_valid);
            end
            tick();
         end
         i_mem_rvalid = 1; i_mem_rdata = rdata;
         #1;
         nvec++;
         if ({o_stall, o_mem_req} !== 2'b10) begin
            nerr++; $display("FAIL ld_resp_cycle: got stall=%b req=%b want 1,0", o_stall, o_mem_req);
         end
         tick();
         i_mem_rvalid = 0;
         #1;
         nvec++;
         if ({o_wb_valid, o_wb_rd, o_wb_data, o_stall, o_bus_err} !== {1'b1, rd, exp, 1'b0, 1'b0}) begin
            nerr++;
            $display("FAIL ld_wb: f3=%0d addr=%h got v=%b rd=%0d d=%h stall=%b berr=%b want v=1 rd=%0d d=%h stall=0 berr=0",
                     f3, addr, o_wb_valid, o_wb_rd, o_wb_data, o_stall, o_bus_err, rd, exp);
         end
         tick();
         nvec++;
         if (o_wb_valid !== 1'b0) begin
            nerr++; $display("FAIL ld_wb_pulse: got %b want 0", o_wb_valid);
         end
      end
   endtask

   task automatic test_store(input int n);
      for (int t = 0; t < n; t++) begin
         logic [2:0]  f3;
         logic [31:0] addr, data;
         int gd, stall_cycles;
         f3 = 3'($urandom_range(0, 2)); addr = rand_aligned(f3); data = $urandom;
         gd = $urandom_range(0, 3);
         if (t == 0) begin
            f3 = LH; addr = 32'h0000_2002; data = 32'h0000_BEEF; gd = 0;
         end
         stall_cycles = 0;
         i_valid = 1; i_is_load = 0; i_is_store = 1; i_func3 = f3;
         i_alu_result = addr; i_store_data = data; i_rd = 5'($urandom);
         #1;
         if (o_stall === 1'b1) stall_cycles++;
         tick();
         i_valid = 0;
         for (int g = 0; g <= gd; g++) begin
            i_mem_gnt = (g == gd);
            #1;
            if (o_stall === 1'b1) stall_cycles++;
            nvec++;
            if ({o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata} !==
                {1'b1, 1'b1, addr[31:2], 2'b00, m_be(f3, addr), m_wdata(f3, data)}) begin
               nerr++;
               $display("FAIL st_req: got req=%b we=%b addr=%h be=%b wd=%h want 1,1 addr=%h be=%b wd=%h",
                        o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata,
                        {addr[31:2], 2'b00}, m_be(f3, addr), m_wdata(f3, data));
            end
            tick();
         end
         i_mem_gnt = 0;
         #1;
         if (o_stall === 1'b1) stall_cycles++;
         nvec++;
         if ({o_mem_req, o_wb_valid} !== 2'b00) begin
            nerr++; $display("FAIL st_done: got req=%b wbv=%b want 0,0", o_mem_req, o_wb_valid);
         end
         nvec++;
         if (stall_cycles != gd + 2) begin
            nerr++; $display("FAIL st_stall_len: got %0d cycles want %0d", stall_cycles, gd + 2);
         end
      end
   endtask

   task automatic test_misaligned(input int n);
      for (int t = 0; t < n; t++) begin
         logic [2:0]  f3;
         logic [31:0] addr;
         bit st;
         st = ($urandom_range(0, 1) == 1);
         f3 = st ? 3'($urandom_range(1, 2)) : ((($urandom_range(0, 1)) == 1) ? LHU : 3'($urandom_range(1, 2)));
         addr = $urandom;
         if (nbytes(f3) == 2) addr[0] = 1'b1;
         else if (addr[1:0] == 2'b00) addr[1] = 1'b1;
         if (t == 0) begin
            st = 0; f3 = LW; addr = 32'h0000_3001;
         end
         i_valid = 1; i_is_load = !st; i_is_store = st; i_func3 = f3;
         i_alu_result = addr; i_rd = 5'($urandom);
         #1;
         nvec++;
         if ({o_stall, o_mem_req} !== 2'b00) begin
            nerr++; $display("FAIL mis_accept: got stall=%b req=%b want 0,0", o_stall, o_mem_req);
         end
         tick();
         i_valid = 0;
         #1;
         nvec++;
         if ({o_misaligned, o_mem_req, o_wb_valid, o_stall} !== 4'b1000) begin
            nerr++; $display("FAIL mis_pulse: f3=%0d addr=%h got mis=%b req=%b wbv=%b stall=%b want 1,0,0,0",
                             f3, addr, o_misaligned, o_mem_req, o_wb_valid, o_stall);
         end
         tick();
         nvec++;
         if ({o_misaligned, o_mem_req} !== 2'b00) begin
            nerr++; $display("FAIL mis_after: got mis=%b req=%b want 0,0", o_misaligned, o_mem_req);
         end
      end
   endtask

   task automatic test_timeout();
      int k;
      logic [31:0] d, rdata;
      // Case 1: no response at all
      i_valid = 1; i_is_load = 1; i_is_store = 0; i_func3 = LHU;
      i_alu_result = 32'h0000_4000; i_rd = 5'd9;
      tick();
      i_valid = 0; i_mem_gnt = 1;
      tick();
      i_mem_gnt = 0;
      k = 0;
      while (k < 3 * TIMEOUT) begin
         if (o_bus_err === 1'b1) break;
         nvec++;
         if ({o_stall, o_wb_valid} !== 2'b10) begin
            nerr++; $display("FAIL to_wait: cycle %0d got stall=%b wbv=%b want 1,0", k, o_stall, o_wb_valid);
         end
         tick();
         k++;
      end
      nvec++;
      if (k != TIMEOUT) begin
         nerr++; $display("FAIL to_cycles: bus error after %0d wait cycles want %0d", k, TIMEOUT);
      end
      d = $urandom;
      i_valid = 1; i_is_load = 0; i_alu_result = d; i_rd = 5'd3;
      #1;
      nvec++;
      if ({o_stall, o_wb_valid} !== 2'b00) begin
         nerr++; $display("FAIL to_next_accept: got stall=%b wbv=%b want 0,0", o_stall, o_wb_valid);
      end
      tick();
      i_valid = 0;
      #1;
      nvec++;
      if ({o_wb_valid, o_wb_rd, o_wb_data, o_bus_err} !== {1'b1, 5'd3, d, 1'b0}) begin
         nerr++; $display("FAIL to_next_wb: got v=%b rd=%0d d=%h berr=%b want 1,3,%h,0",
                          o_wb_valid, o_wb_rd, o_wb_data, o_bus_err, d);
      end
      tick();
      // Case 2: response arrives in the last permitted wait cycle
      rdata = $urandom;
      i_valid = 1; i_is_load = 1; i_func3 = LW; i_alu_result = rand_aligned(LW); i_rd = 5'd17;
      tick();
      i_valid = 0; i_mem_gnt = 1;
      tick();
      i_mem_gnt = 0;
      for (int w = 0; w < TIMEOUT - 1; w++) tick();
      i_mem_rvalid = 1; i_mem_rdata = rdata;
      tick();
      i_mem_rvalid = 0;
      #1;
      nvec++;
      if ({o_wb_valid, o_wb_rd, o_wb_data, o_bus_err} !== {1'b1, 5'd17, rdata, 1'b0}) begin
         nerr++; $display("FAIL to_rvalid_wins: got v=%b rd=%0d d=%h berr=%b want 1,17,%h,0",
                          o_wb_valid, o_wb_rd, o_wb_data, o_bus_err, rdata);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      i_valid = 1; i_is_load = 1; i_is_store = 0; i_func3 = LW;
      i_alu_result = rand_aligned(LW); i_rd = 5'd7;
      tick();
      i_valid = 0;
      #1;
      nvec++;
      if (o_mem_req !== 1'b1) begin
         nerr++; $display("FAIL rst_mid_req: got %b want 1", o_mem_req);
      end
      i_reset = 1;
      tick();
      i_reset = 0;
      #1;
      nvec++;
      if ({o_mem_req, o_stall} !== 2'b00) begin
         nerr++; $display("FAIL rst_mid_drop: got req=%b stall=%b want 0,0", o_mem_req, o_stall);
      end
      for (int c = 0; c < 3; c++) begin
         i_mem_rvalid = 1; i_mem_rdata = $urandom;
         tick();
         nvec++;
         if ({o_wb_valid, o_bus_err, o_mem_req} !== 3'b000) begin
            nerr++; $display("FAIL rst_stray_rvalid: got wbv=%b berr=%b req=%b want 0,0,0",
                             o_wb_valid, o_bus_err, o_mem_req);
         end
      end
      i_mem_rvalid = 0;
      tick();
   endtask

   // Store then ALU then load then ALU with no idle gaps and minimum latencies.
   task automatic test_back_to_back(input int n);
      for (int t = 0; t < n; t++) begin
         logic [31:0] a1, a2, rdata, laddr;
         logic [2:0]  lf3;
         a1 = $urandom; a2 = $urandom; rdata = $urandom;
         lf3 = rand_load_f3(); laddr = rand_aligned(lf3);
         i_valid = 1; i_is_store = 1; i_is_load = 0; i_func3 = LW;
         i_alu_result = rand_aligned(LW); i_store_data = $urandom;
         tick();
         i_valid = 0; i_mem_gnt = 1;
         tick();
         i_mem_gnt = 0;
         i_valid = 1; i_is_store = 0; i_alu_result = a1; i_rd = 5'd11;
         #1;
         nvec++;
         if (o_stall !== 1'b0) begin
            nerr++; $display("FAIL b2b_st_to_alu: got stall=%b want 0", o_stall);
         end
         tick();
         i_is_load = 1; i_func3 = lf3; i_alu_result = laddr; i_rd = 5'd12;
         #1;
         nvec++;
         if ({o_wb_valid, o_wb_rd, o_wb_data, o_stall} !== {1'b1, 5'd11, a1, 1'b1}) begin
            nerr++; $display("FAIL b2b_alu_wb: got v=%b rd=%0d d=%h stall=%b want 1,11,%h,1",
                             o_wb_valid, o_wb_rd, o_wb_data, o_stall, a1);
         end
         tick();
         i_valid = 0; i_mem_gnt = 1;
         tick();
         i_mem_gnt = 0; i_mem_rvalid = 1; i_mem_rdata = rdata;
         tick();
         i_mem_rvalid = 0;
         i_valid = 1; i_is_load = 0; i_alu_result = a2; i_rd = 5'd13;
         #1;
         nvec++;
         if ({o_wb_valid, o_wb_rd, o_wb_data, o_stall} !== {1'b1, 5'd12, m_load(rdata, laddr, lf3), 1'b0}) begin
            nerr++; $display("FAIL b2b_ld_wb: got v=%b rd=%0d d=%h stall=%b want 1,12,%h,0",
                             o_wb_valid, o_wb_rd, o_wb_data, o_stall, m_load(rdata, laddr, lf3));
         end
         tick();
         i_valid = 0;
         #1;
         nvec++;
         if ({o_wb_valid, o_wb_rd, o_wb_data} !== {1'b1, 5'd13, a2}) begin
            nerr++; $display("FAIL b2b_alu2_wb: got v=%b rd=%0d d=%h want 1,13,%h",
                             o_wb_valid, o_wb_rd, o_wb_data, a2);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_passthrough(12);
      test_load(25);
      test_store(20);
      test_misaligned(10);
      test_timeout();
      test_reset_mid();
      test_back_to_back(8);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog");
   end

endmodule
